// File: rtl/fallthrough_fifo.sv
// First-word-fall-through FIFO: the head word sits on dout whenever the queue is non-empty.
// Flags are decoded from the registered occupancy, so they only move after a clock edge.
module fallthrough_fifo #(
    parameter int WIDTH               = 72,
    parameter int MAX_DEPTH_BITS      = 3,
    parameter int PROG_FULL_THRESHOLD = (1 << MAX_DEPTH_BITS) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty
);

    localparam int MAX_DEPTH = 1 << MAX_DEPTH_BITS;

    localparam logic [MAX_DEPTH_BITS:0] FULL_CNT   = {1'b1, {MAX_DEPTH_BITS{1'b0}}};
    localparam logic [MAX_DEPTH_BITS:0] NEARLY_CNT = FULL_CNT - 1'b1;
    localparam logic [MAX_DEPTH_BITS:0] PROG_CNT   = PROG_FULL_THRESHOLD[MAX_DEPTH_BITS:0];

    logic [WIDTH-1:0]          mem [MAX_DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   count;
    logic                      wr_ok;
    logic                      rd_ok;

    // A write into a full queue is still taken when a pop frees the head slot in the same cycle.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale contents are masked by empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout        = mem[rd_ptr];
    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign nearly_full = (count >= NEARLY_CNT);
    assign prog_full   = (count >= PROG_CNT);

endmodule

// File: tb/tb_fallthrough_fifo.sv
// Directed and queue-referenced checks for fallthrough_fifo at depth 4.
module tb_fallthrough_fifo;

    localparam int W = 72;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] dout;
    logic         full;
    logic         nearly_full;
    logic         prog_full;
    logic         empty;

    int checks = 0;
    int errors = 0;

    fallthrough_fifo #(
        .WIDTH              (W),
        .MAX_DEPTH_BITS     (2),
        .PROG_FULL_THRESHOLD(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .nearly_full(nearly_full),
        .prog_full  (prog_full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic r, input logic [W-1:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic e, input logic pf,
                               input logic nf, input logic f);
        check({tag, ".empty"}, W'(empty), W'(e));
        check({tag, ".prog_full"}, W'(prog_full), W'(pf));
        check({tag, ".nearly_full"}, W'(nearly_full), W'(nf));
        check({tag, ".full"}, W'(full), W'(f));
    endtask

    task automatic fill4();
        drive(1, 0, 72'h11);
        drive(1, 0, 72'h22);
        drive(1, 0, 72'h33);
        drive(1, 0, 72'h44);
    endtask

    logic [W-1:0] q[$];
    int written;
    int cycles;
    logic w, r;
    logic [W-1:0] d;

    initial begin
        #1 reset = 1'b1;
        #1 check_flags("reset_async", 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_flags("idle", 1, 0, 0, 0);

        // Fill sequence
        drive(1, 0, 72'h11);
        check("fill1.dout", dout, 72'h11);
        check_flags("fill1", 0, 0, 0, 0);
        drive(1, 0, 72'h22);
        check_flags("fill2", 0, 1, 0, 0);
        drive(1, 0, 72'h33);
        check_flags("fill3", 0, 1, 1, 0);
        drive(1, 0, 72'h44);
        check_flags("fill4", 0, 1, 1, 1);
        check("fill4.dout", dout, 72'h11);

        // Overflow write is dropped
        drive(1, 0, 72'h55);
        check_flags("ovf", 0, 1, 1, 1);
        check("ovf.dout", dout, 72'h11);
        drive(0, 1, '0);
        check("pop1", dout, 72'h22);
        check_flags("pop1", 0, 1, 1, 0);
        drive(0, 1, '0);
        check("pop2", dout, 72'h33);
        drive(0, 1, '0);
        check("pop3", dout, 72'h44);
        check_flags("pop3", 0, 0, 0, 0);
        drive(0, 1, '0);
        check_flags("pop4", 1, 0, 0, 0);

        // Simultaneous read/write on full
        fill4();
        drive(1, 1, 72'h66);
        check("rw_full.dout", dout, 72'h22);
        check_flags("rw_full", 0, 1, 1, 1);
        drive(0, 1, '0);
        check("rwf_pop1", dout, 72'h33);
        drive(0, 1, '0);
        check("rwf_pop2", dout, 72'h44);
        drive(0, 1, '0);
        check("rwf_pop3", dout, 72'h66);
        drive(0, 1, '0);
        check_flags("rwf_drain", 1, 0, 0, 0);

        // Read+write on empty; read alone on empty
        drive(1, 1, 72'h77);
        check("rw_empty.dout", dout, 72'h77);
        check_flags("rw_empty", 0, 0, 0, 0);
        drive(0, 1, '0);
        check_flags("rw_empty_pop", 1, 0, 0, 0);
        drive(0, 1, '0);
        check_flags("udf", 1, 0, 0, 0);
        drive(1, 0, 72'h88);
        check("udf_write.dout", dout, 72'h88);
        check_flags("udf_write", 0, 0, 0, 0);
        drive(0, 1, '0);
        check_flags("udf_drain", 1, 0, 0, 0);

        // Reset mid-stream with three words held
        drive(1, 0, 72'hA1);
        drive(1, 0, 72'hB2);
        drive(1, 0, 72'hC3);
        check_flags("pre_rst", 0, 1, 1, 0);
        #2 reset = 1'b1;
        #1 check_flags("mid_rst", 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_flags("post_rst", 1, 0, 0, 0);
        drive(1, 0, 72'hD1);
        check("post_rst.dout", dout, 72'hD1);
        drive(0, 1, '0);
        check_flags("post_rst_pop", 1, 0, 0, 0);

        // Random stress against a reference queue, writer gated by nearly_full
        written = 0;
        cycles  = 0;
        while ((written < 1000 || q.size() != 0) && cycles < 20000) begin
            w = (written < 1000) && !nearly_full && ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 1) == 1;
            d = {$urandom(), $urandom(), 8'(written)};
            if (full && w) check("stress.overflow_attempt", 1, 0);
            check("stress.empty", W'(empty), W'(q.size() == 0));
            if (r && q.size() != 0) begin
                check("stress.dout", dout, q[0]);
                void'(q.pop_front());
            end
            if (w) begin
                q.push_back(d);
                written++;
            end
            drive(w, r, d);
            cycles++;
        end
        check("stress.budget", W'(cycles < 20000), W'(1));
        check_flags("stress.end", 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
